// File: rtl/board_mem_arbiter_if.sv
// Request, response and RAM-command bundle between the board RAM arbiter, its two
// requesters (VGA reader, game FSM) and the single-port board RAM.
interface board_mem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic [DATA_W-1:0] vga_rdata;
   logic              vga_rvalid;
   logic              vga_miss;

   logic              fsm_req;
   logic              fsm_we;
   logic [ADDR_W-1:0] fsm_addr;
   logic [DATA_W-1:0] fsm_wdata;
   logic              fsm_gnt;
   logic [DATA_W-1:0] fsm_rdata;
   logic              fsm_rvalid;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  vga_req, vga_addr, fsm_req, fsm_we, fsm_addr, fsm_wdata, mem_rdata,
      output vga_rdata, vga_rvalid, vga_miss, fsm_gnt, fsm_rdata, fsm_rvalid,
             mem_addr, mem_we, mem_wdata
   );

   modport master (
      output vga_req, vga_addr, fsm_req, fsm_we, fsm_addr, fsm_wdata, mem_rdata,
      input  vga_rdata, vga_rvalid, vga_miss, fsm_gnt, fsm_rdata, fsm_rvalid,
             mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/board_mem_arbiter.sv
// Board RAM arbiter: VGA reads win over FSM commands unless the FSM has lost STARVE_LIMIT times in a row.
// One command per cycle, issued 1 cycle after arbitration, read data 3 cycles after; VGA never stalls.
module board_mem_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 64
) (
   input  logic               clk,
   input  logic               rst,
   board_mem_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic vld;
      logic own_fsm;
      logic miss;
   } tag_t;

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              fsm_gnt_q, fsm_gnt_d;
   tag_t              tag1_q, tag1_d, tag2_q, tag2_d;
   logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
   logic [DATA_W-1:0] fsm_rdata_q, fsm_rdata_d;
   logic              vga_rvalid_q, vga_rvalid_d;
   logic              vga_miss_q, vga_miss_d;
   logic              fsm_rvalid_q, fsm_rvalid_d;

   logic fsm_eligible;
   logic starve_hit;
   logic fsm_win;
   logic vga_win;

   always_comb begin
      // A request whose grant is visible this cycle is the one just accepted, not a new one.
      fsm_eligible = bus.fsm_req && !fsm_gnt_q;
      starve_hit   = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
      fsm_win      = fsm_eligible && (!bus.vga_req || starve_hit);
      vga_win      = bus.vga_req && !fsm_win;

      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      if (fsm_win) begin
         mem_addr_d  = bus.fsm_addr;
         mem_we_d    = bus.fsm_we;
         mem_wdata_d = bus.fsm_wdata;
      end else if (vga_win) begin
         mem_addr_d  = bus.vga_addr;
      end
      fsm_gnt_d = fsm_win;

      starve_cnt_d = starve_cnt_q;
      if (!bus.fsm_req || fsm_gnt_q || fsm_win) begin
         starve_cnt_d = '0;
      end else if (!starve_hit) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end

      tag1_d.vld     = vga_win || (fsm_win && !bus.fsm_we);
      tag1_d.own_fsm = fsm_win;
      tag1_d.miss    = bus.vga_req && fsm_win;
      tag2_d         = tag1_q;

      // tag2 lines up with the RAM's read data for the command issued last cycle.
      vga_rvalid_d = tag2_q.vld && !tag2_q.own_fsm;
      fsm_rvalid_d = tag2_q.vld && tag2_q.own_fsm;
      vga_miss_d   = tag2_q.miss;
      vga_rdata_d  = vga_rvalid_d ? bus.mem_rdata : vga_rdata_q;
      fsm_rdata_d  = fsm_rvalid_d ? bus.mem_rdata : fsm_rdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         fsm_gnt_q    <= 1'b0;
         tag1_q       <= '0;
         tag2_q       <= '0;
         vga_rdata_q  <= '0;
         fsm_rdata_q  <= '0;
         vga_rvalid_q <= 1'b0;
         vga_miss_q   <= 1'b0;
         fsm_rvalid_q <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         fsm_gnt_q    <= fsm_gnt_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag2_d;
         vga_rdata_q  <= vga_rdata_d;
         fsm_rdata_q  <= fsm_rdata_d;
         vga_rvalid_q <= vga_rvalid_d;
         vga_miss_q   <= vga_miss_d;
         fsm_rvalid_q <= fsm_rvalid_d;
      end
   end

   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.fsm_gnt    = fsm_gnt_q;
   assign bus.fsm_rdata  = fsm_rdata_q;
   assign bus.fsm_rvalid = fsm_rvalid_q;
   assign bus.vga_rdata  = vga_rdata_q;
   assign bus.vga_rvalid = vga_rvalid_q;
   assign bus.vga_miss   = vga_miss_q;
endmodule
